cpu_opcode_fetch: RTL

- M1 opcode-fetch sequencer on the register-file side of the CPU.
- Reads the 16-bit PC from the register file and runs the Z80-style M1 bus cycle: T1, T2, optional Tw wait states, T3, T4.
- Pulses `reg_pc_inc` back to the register file, latches the opcode, and hands it to the decoder with a valid/ack handshake.
- Drives the refresh half of M1 (T3/T4) using I and an internal 7-bit R counter.

---
 rtl/cpu_opcode_fetch_pkg.sv | 19 +
 rtl/cpu_refresh_counter.sv | 29 ++
 rtl/cpu_opcode_fetch.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cpu_opcode_fetch_pkg.sv
// Shared constants for the M1 opcode-fetch sequencer: state encodings,
// strobe idle level and default bus widths.
package cpu_opcode_fetch_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4,
    T4   = 3'd5
  } fetch_state_e;

endpackage

// File: rtl/cpu_refresh_counter.sv
// Z80-style refresh register R: loadable, low R_BITS auto-increment,
// upper bits preserved across increments.
module cpu_refresh_counter
  import cpu_opcode_fetch_pkg::*;
#(
  parameter int R_BITS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       inc,
  output logic [7:0] r
);

  localparam logic [7:0] LOW_MASK = 8'((9'd1 << R_BITS) - 9'd1);

  // A load (LD R,A) beats the end-of-M1 increment landing in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= '0;
    end else if (load) begin
      r <= load_value;
    end else if (inc) begin
      r <= (r & ~LOW_MASK) | ((r + 8'd1) & LOW_MASK);
    end
  end

endmodule

// File: rtl/cpu_opcode_fetch.sv
// M1 opcode-fetch sequencer: runs T1/T2/Tw/T3/T4, bumps the PC once per
// fetch, hands the opcode to the decoder and drives the refresh half.
module cpu_opcode_fetch
  import cpu_opcode_fetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int R_BITS = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] reg_pc,
  output logic              reg_pc_inc,
  input  logic [7:0]        i_reg,
  input  logic              r_load,
  input  logic [7:0]        r_in,
  output logic [7:0]        r_out,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              wait_n,
  output logic              m1_n,
  output logic              mreq_n,
  output logic              rd_n,
  output logic              rfsh_n,
  output logic [DATA_W-1:0] opcode,
  output logic              opcode_valid,
  input  logic              opcode_ack,
  output logic              busy
);

  fetch_state_e state, state_next;
  logic         go;
  logic         latch_op;
  logic         r_inc;
  logic [7:0]   r_value;

  assign go       = fetch_req && (!opcode_valid || opcode_ack);
  assign latch_op = ((state == T2) || (state == TW)) && wait_n;
  assign r_inc    = (state == T4);
  assign r_out    = r_value;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = T1;
      T1:      state_next = T2;
      T2, TW:  state_next = wait_n ? T3 : TW;
      T3:      state_next = T4;
      T4:      state_next = go ? T1 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and the PC-increment pulse are pure decodes of the state, so the
  // increment can only ever fire once per fetch, in T2.
  always_comb begin
    m1_n       = STROBE_OFF;
    mreq_n     = STROBE_OFF;
    rd_n       = STROBE_OFF;
    rfsh_n     = STROBE_OFF;
    reg_pc_inc = 1'b0;
    case (state)
      T1, T2, TW: begin
        m1_n   = 1'b0;
        mreq_n = 1'b0;
        rd_n   = 1'b0;
        if (state == T2) reg_pc_inc = 1'b1;
      end
      T3: begin
        mreq_n = 1'b0;
        rfsh_n = 1'b0;
      end
      T4: begin
        rfsh_n = 1'b0;
      end
      default: ;
    endcase
  end

  // The refresh address is captured on the way into T3 so it stays stable
  // through T4 even if R is reloaded mid-refresh.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr         <= '0;
      opcode       <= '0;
      opcode_valid <= 1'b0;
    end else begin
      if (((state == IDLE) || (state == T4)) && go) begin
        addr <= reg_pc;
      end else if (latch_op) begin
        addr <= ADDR_W'({i_reg, r_value});
      end
      if (latch_op) begin
        opcode       <= data_in;
        opcode_valid <= 1'b1;
      end else if (opcode_ack) begin
        opcode_valid <= 1'b0;
      end
    end
  end

  cpu_refresh_counter #(
    .R_BITS(R_BITS)
  ) u_refresh (
    .clk       (clk),
    .reset     (reset),
    .load      (r_load),
    .load_value(r_in),
    .inc       (r_inc),
    .r         (r_value)
  );

endmodule
